div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the execute stage's divide/remainder operations (div, divu, rem, remu).
- Replaces the single-cycle combinational divide path with a radix-2 restoring iteration of one quotient bit per cycle.
- Stalls the pipeline while busy, returns one result pulse, and supports cancellation by pipeline flush.
- Sits beside the execute ALU; its result is muxed into the execute result when the done pulse is high.

Parameters:
- XLEN, 32, operand/result width; must match the global `XLEN.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- DD_div_start_i  in  1  request a divide this cycle; sampled only in IDLE
- DD_div_op_i  in  4  one-hot {remu,rem,divu,div}; sampled with start
- DD_rs1_data_i  in  XLEN  dividend
- DD_rs2_data_i  in  XLEN  divisor
- E_flush_i  in  1  cancel any in-flight operation
- E_div_stall_o  out  1  hold upstream pipeline registers
- E_div_valid_o  out  1  one-cycle pulse: result valid
- E_div_result_o  out  XLEN  quotient or remainder, held until next start

Behaviour:
- Reset: state=IDLE, counter=0, E_div_stall_o=0, E_div_valid_o=0, E_div_result_o=0. Reset dominates every other input.
- States: IDLE, CALC, FIX, DONE.
- IDLE, with start=1 and flush=0:
  - latch op; compute magnitudes for signed ops (|rs1|, |rs2|); record sign_q = rs1[msb]^rs2[msb] and sign_r = rs1[msb].
  - divisor==0 -> go to DONE with quotient=all-ones and remainder=rs1.
  - signed overflow (rs1=100..0, rs2=all-ones, div/rem only) -> go to DONE with quotient=rs1 and remainder=0.
  - otherwise -> go to CALC with counter=XLEN.
- CALC: each cycle, shift {rem,quo} left by 1 and trial-subtract the divisor from rem.
  - no borrow: keep the difference and set quo[0]=1; borrow: set quo[0]=0.
  - counter decrements; at counter==1 go to FIX.
- FIX: negate quotient if signed op and sign_q; negate remainder if signed op and sign_r. Select quotient (div/divu) or remainder (rem/remu) into the result register. Go to DONE.
- DONE: E_div_valid_o=1 for exactly this cycle; next state IDLE.
- Latency, start cycle = 0:
  - normal ops: valid at cycle XLEN+2 (34 for XLEN=32).
  - special cases: valid at cycle 1.
- Stall:
  - E_div_stall_o = (IDLE & start & ~flush) | CALC | FIX. Combinational from start in IDLE.
  - Deasserted in DONE so the pipeline advances in the same cycle the result is consumed.
- Flush: in any state, E_flush_i=1 sends the block to IDLE next cycle, suppresses valid, and leaves the result register unchanged. Flush in DONE still lets that cycle's valid pulse through, because it is already presented. Start together with flush in IDLE is ignored.
- Start outside IDLE is ignored; upstream is stalled, so this does not occur in a legal flow.
- Illegal op encoding (not one-hot, or zero) with start: treated as divu.
- Arithmetic: the remainder accumulator is XLEN+1 bits so the trial subtract exposes the borrow; all negation is two's complement modulo 2^XLEN.

Decomposition:
- Shared define file (the existing global defines include):
  - state encodings DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE;
  - div-op one-hot bit indices `div_div`, `div_divu`, `div_rem`, `div_remu`, consistent with the existing ALU op indices.
- One natural sub-module: div_iter_step. Combinational single-bit restoring step; inputs rem, quo, divisor; outputs next rem and next quo. Instantiated once inside div_seq_ctrl.
- FSM, counter, sign handling and special-case detection stay in div_seq_ctrl.

Test Plan:
- divu 100/7: start at cycle 0 -> stall high cycles 0-33; valid pulse at cycle 34 with result 14. remu with the same operands -> 2.
- div -7/2 -> -3 (0xFFFFFFFD). rem -7/2 -> -1 (0xFFFFFFFF). Both valid at cycle 34.
- Divide by zero: div 5/0 -> 0xFFFFFFFF valid at cycle 1, stall high only in cycle 0. rem 5/0 -> 5.
- Overflow: div 0x80000000/0xFFFFFFFF -> 0x80000000 valid at cycle 1. rem with the same operands -> 0.
- Flush at cycle 10 of a divu -> IDLE at cycle 11, no valid pulse, stall low from cycle 11. A new start at cycle 12 (divu 9/3) -> result 3 valid at cycle 46.
- rst asserted mid-CALC -> next cycle all outputs 0, state IDLE. A start held high during the rst cycle is not accepted.

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
// Shared types for the execute-stage iterative divider.
// State encodings, op bit indices and the op decoder.
package div_seq_ctrl_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  localparam int DIV_DIV  = 0;
  localparam int DIV_DIVU = 1;
  localparam int DIV_REM  = 2;
  localparam int DIV_REMU = 3;

  typedef struct packed {
    logic sgn;
    logic rem;
  } div_op_t;

  // Anything that is not a clean one-hot code falls back to divu.
  function automatic div_op_t div_decode(input logic [3:0] op);
    div_op_t d;
    d = '{sgn: 1'b0, rem: 1'b0};
    case (op)
      4'(1 << DIV_DIV):  d.sgn = 1'b1;
      4'(1 << DIV_REM):  d = '{sgn: 1'b1, rem: 1'b1};
      4'(1 << DIV_REMU): d.rem = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/result bundle between the execute stage and the divider.
// master = pipeline side, slave = divider side.
interface div_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            DD_div_start_i;
  logic [3:0]      DD_div_op_i;
  logic [XLEN-1:0] DD_rs1_data_i;
  logic [XLEN-1:0] DD_rs2_data_i;
  logic            E_flush_i;
  logic            E_div_stall_o;
  logic            E_div_valid_o;
  logic [XLEN-1:0] E_div_result_o;

  modport master (
    output DD_div_start_i,
    output DD_div_op_i,
    output DD_rs1_data_i,
    output DD_rs2_data_i,
    output E_flush_i,
    input  E_div_stall_o,
    input  E_div_valid_o,
    input  E_div_result_o
  );

  modport slave (
    input  DD_div_start_i,
    input  DD_div_op_i,
    input  DD_rs1_data_i,
    input  DD_rs2_data_i,
    input  E_flush_i,
    output E_div_stall_o,
    output E_div_valid_o,
    output E_div_result_o
  );
endinterface

// File: rtl/div_iter_step.sv
// One radix-2 restoring step: shift {rem,quo} left and
// trial-subtract the divisor, keeping the difference on no borrow.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN+1:0] sh;
  logic [XLEN:0]   diff;
  logic            borrow;

  assign sh      = {rem, quo[XLEN-1]};
  assign borrow  = sh < {2'b00, divisor};
  assign diff    = sh[XLEN:0] - {1'b0, divisor};
  assign rem_nxt = borrow ? sh[XLEN:0] : diff;
  assign quo_nxt = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle div/divu/rem/remu sequencer for the execute stage.
// Stalls upstream while iterating; one-cycle valid pulse on result.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  div_seq_ctrl_if.slave bus
);

  div_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  div_op_t         op_q;
  logic            sign_q;
  logic            sign_r;
  logic            busy_q;
  logic            valid_q;
  logic [XLEN-1:0] result_q;

  div_op_t         dec;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div0;
  logic            ovf;
  logic            take;
  logic [XLEN-1:0] sp_q;
  logic [XLEN-1:0] sp_r;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign dec  = div_decode(bus.DD_div_op_i);
  assign rs1  = bus.DD_rs1_data_i;
  assign rs2  = bus.DD_rs2_data_i;
  assign mag1 = (dec.sgn && rs1[XLEN-1]) ? -rs1 : rs1;
  assign mag2 = (dec.sgn && rs2[XLEN-1]) ? -rs2 : rs2;
  assign div0 = rs2 == '0;
  assign ovf  = dec.sgn && (rs1 == {1'b1, {(XLEN-1){1'b0}}})
              && (&rs2);
  assign take = (state == DIV_IDLE) && bus.DD_div_start_i
              && !bus.E_flush_i;

  assign sp_q = div0 ? '1 : rs1;
  assign sp_r = div0 ? rs1 : '0;

  assign q_fix = (op_q.sgn && sign_q) ? -quo_q : quo_q;
  assign r_fix = (op_q.sgn && sign_r) ? -rem_q[XLEN-1:0]
                                      : rem_q[XLEN-1:0];

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvsr_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      op_q     <= '{sgn: 1'b0, rem: 1'b0};
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.E_flush_i) begin
        state  <= DIV_IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          DIV_IDLE: begin
            if (bus.DD_div_start_i) begin
              op_q   <= dec;
              sign_q <= rs1[XLEN-1] ^ rs2[XLEN-1];
              sign_r <= rs1[XLEN-1];
              if (div0 || ovf) begin
                result_q <= dec.rem ? sp_r : sp_q;
                valid_q  <= 1'b1;
                state    <= DIV_DONE;
              end else begin
                rem_q  <= '0;
                quo_q  <= mag1;
                dvsr_q <= mag2;
                cnt    <= CNT_W'(XLEN);
                busy_q <= 1'b1;
                state  <= DIV_CALC;
              end
            end
          end
          DIV_CALC: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= DIV_FIX;
          end
          DIV_FIX: begin
            result_q <= op_q.rem ? r_fix : q_fix;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state    <= DIV_DONE;
          end
          DIV_DONE: state <= DIV_IDLE;
        endcase
      end
    end
  end

  assign bus.E_div_stall_o  = busy_q | take;
  assign bus.E_div_valid_o  = valid_q;
  assign bus.E_div_result_o = result_q;

endmodule
